// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_controller
//  Description : Horizontal VGA timing generator with pixel-clock divider,
//                run/drain control and strobes for an external line counter.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_controller #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_LEN   = 2,
    parameter int V_TOTAL      = 525,
    parameter int PIXEL_DIV    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] V_count_value,
    output logic        enable_V_counter,
    output logic [15:0] H_count_value,
    output logic        pixel_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start,
    output logic        busy
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_DIV_W   = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(PIXEL_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);

    localparam logic [15:0] c_FP_START   = 16'(H_VISIBLE);
    localparam logic [15:0] c_SYNC_START = 16'(H_VISIBLE + H_FP);
    localparam logic [15:0] c_BP_START   = 16'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [15:0] c_H_LAST     = 16'(c_H_TOTAL - 1);
    localparam logic [15:0] c_VS_START   = 16'(V_SYNC_START);
    localparam logic [15:0] c_VS_END     = 16'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [15:0] c_V_VISIBLE  = 16'(V_VISIBLE);
    localparam logic [15:0] c_V_TOTAL    = 16'(V_TOTAL);
    localparam logic [15:0] c_V_LAST     = 16'(V_TOTAL - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [1:0] c_PH_ACTIVE = 2'd0;
    localparam logic [1:0] c_PH_FRONT  = 2'd1;
    localparam logic [1:0] c_PH_SYNC   = 2'd2;
    localparam logic [1:0] c_PH_BACK   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_next;
    logic [15:0]        r_h;
    logic [15:0]        w_h_next;
    logic [1:0]         r_phase;
    logic [1:0]         w_phase_next;
    logic               r_start_pulse;
    logic               w_busy;
    logic               w_tick;
    logic               w_line_end;
    logic               w_eof;
    logic               w_v_in_frame;

    assign w_busy       = (r_state != c_IDLE);
    assign w_tick       = w_busy && (r_div == c_DIV_MAX);
    assign w_line_end   = w_tick && (r_h == c_H_LAST);
    assign w_eof        = w_line_end && (V_count_value == c_V_LAST);
    assign w_v_in_frame = (V_count_value < c_V_TOTAL);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (run) w_state_next = c_RUN;
            c_RUN:   if (!run) w_state_next = c_DRAIN;
            c_DRAIN: begin
                // A re-request during drain wins over the end-of-frame stop.
                if (run)        w_state_next = c_RUN;
                else if (w_eof) w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_div_next = r_div;
        w_h_next   = r_h;
        if (r_state == c_IDLE) begin
            w_div_next = '0;
            w_h_next   = '0;
        end else if (w_tick) begin
            w_div_next = '0;
            w_h_next   = (r_h == c_H_LAST) ? 16'd0 : r_h + 16'd1;
        end else begin
            w_div_next = r_div + c_DIV_ONE;
        end
    end

    // Phase follows the next count so it switches on the same edge as H.
    always_comb begin
        w_phase_next = c_PH_ACTIVE;
        if (w_h_next >= c_BP_START)        w_phase_next = c_PH_BACK;
        else if (w_h_next >= c_SYNC_START) w_phase_next = c_PH_SYNC;
        else if (w_h_next >= c_FP_START)   w_phase_next = c_PH_FRONT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_div         <= '0;
            r_h           <= '0;
            r_phase       <= c_PH_ACTIVE;
            r_start_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_div         <= w_div_next;
            r_h           <= w_h_next;
            r_phase       <= w_phase_next;
            r_start_pulse <= (r_state == c_IDLE) && (w_state_next == c_RUN);
        end
    end

    assign busy             = w_busy;
    assign pixel_tick       = w_tick;
    assign enable_V_counter = w_line_end;
    assign H_count_value    = r_h;
    assign hsync            = !(w_busy && (r_phase == c_PH_SYNC));
    assign vsync            = !(w_busy && w_v_in_frame &&
                                (V_count_value >= c_VS_START) &&
                                (V_count_value <  c_VS_END));
    assign video_on         = w_busy && (r_phase == c_PH_ACTIVE) && w_v_in_frame &&
                              (V_count_value < c_V_VISIBLE);
    assign frame_start      = r_start_pulse || ((r_state == c_RUN) && w_eof);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_controller
//  Description : Randomised bench for vga_timing_controller against a
//                cycle-count model of the video timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_controller;

    localparam int c_DIV  = 4;
    localparam int c_HT   = 800;
    localparam int c_LINE = c_DIV * c_HT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [15:0] V_count_value = 16'd0;
    logic        enable_V_counter;
    logic [15:0] H_count_value;
    logic        pixel_tick;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_start;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 run, 2 drain; timing is a pure function of the
    // number of clocks elapsed since the frame generator was started.
    int m_mode  = 0;
    int m_clk   = 0;
    bit m_start = 1'b0;

    vga_timing_controller dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .V_count_value    (V_count_value),
        .enable_V_counter (enable_V_counter),
        .H_count_value    (H_count_value),
        .pixel_tick       (pixel_tick),
        .hsync            (hsync),
        .vsync            (vsync),
        .video_on         (video_on),
        .frame_start      (frame_start),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic int m_h();
        return (m_mode != 0) ? (m_clk / c_DIV) % c_HT : 0;
    endfunction

    function automatic bit m_tick();
        return (m_mode != 0) && ((m_clk % c_DIV) == c_DIV - 1);
    endfunction

    function automatic bit m_eof();
        return m_tick() && (m_h() == c_HT - 1) && (V_count_value == 16'd524);
    endfunction

    function automatic logic [22:0] exp_vec();
        int h;
        bit b, t, env, hs, vs, von, fs;
        if (!reset) return {16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        b   = (m_mode != 0);
        t   = m_tick();
        h   = m_h();
        env = t && (h == c_HT - 1);
        hs  = !(b && h >= 656 && h <= 751);
        vs  = !(b && V_count_value >= 16'd490 && V_count_value <= 16'd491);
        von = b && (h < 640) && (V_count_value < 16'd480);
        fs  = m_start || (m_mode == 1 && m_eof());
        return {16'(h), t, env, hs, vs, von, fs, b};
    endfunction

    always @(posedge clk) begin
        bit eof_now;
        bit started;
        started = 1'b0;
        if (!reset) begin
            m_mode = 0;
            m_clk  = 0;
        end else begin
            eof_now = m_eof();
            case (m_mode)
                0: if (run) begin m_mode = 1; m_clk = 0; started = 1'b1; end
                1: begin m_clk++; if (!run) m_mode = 2; end
                default: begin
                    m_clk++;
                    if (run) m_mode = 1;
                    else if (eof_now) begin m_mode = 0; m_clk = 0; end
                end
            endcase
        end
        m_start = started;
    end

    always @(negedge clk) begin
        logic [22:0] act;
        logic [22:0] exp;
        act = {H_count_value, pixel_tick, enable_V_counter, hsync, vsync, video_on,
               frame_start, busy};
        exp = exp_vec();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t act={H,tick,envc,hs,vs,von,fs,busy}=%h required=%h",
                     $time, act, exp);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_line_start();
        int k;
        k = 0;
        while ((m_clk % c_LINE) != 0 && k < c_LINE + 10) begin
            step(1);
            k++;
        end
        check("line_start_reached", int'(k < c_LINE + 10), 1);
    endtask

    initial begin
        int k, hs_low, env_cnt, h_env, fs_cnt, both;
        // Reset held with run requested: everything stays at idle values.
        reset = 1'b0; run = 1'b1; V_count_value = 16'd490;
        step(3);
        check("rst_busy", busy, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_H", H_count_value, 0);
        check("rst_fs", frame_start, 0);
        check("rst_tick", pixel_tick, 0);
        V_count_value = 16'd0;

        reset = 1'b1;
        step(1);
        check("start_fs", frame_start, 1);
        check("start_busy", busy, 1);
        k = 0;
        while (!pixel_tick && k < 10) begin step(1); k++; end
        check("first_tick_delay", k, 3);
        k = 0;
        do begin step(1); k++; end while (!pixel_tick && k < 10);
        check("tick_period", k, 4);

        // One full line.
        to_line_start();
        V_count_value = 16'd100;
        hs_low = 0; env_cnt = 0; h_env = -1;
        for (int i = 0; i < c_LINE; i++) begin
            if (!hsync) hs_low++;
            if (enable_V_counter) begin env_cnt++; h_env = H_count_value; end
            step(1);
        end
        check("hsync_low_clks", hs_low, 384);
        check("envc_per_line", env_cnt, 1);
        check("envc_at_H", h_env, 799);

        // Vertical sync / visible boundaries at the start of a line.
        for (int v = 489; v <= 492; v++) begin
            V_count_value = 16'(v);
            step(1);
            check("vsync_at_V", vsync, (v == 490 || v == 491) ? 0 : 1);
        end
        V_count_value = 16'd479; step(1); check("video_on_V479", video_on, 1);
        V_count_value = 16'd480; step(1); check("video_on_V480", video_on, 0);
        V_count_value = 16'd600; step(1); check("out_of_frame_vsync", vsync, 1);
        V_count_value = 16'd600; check("out_of_frame_video", video_on, 0);

        // Drop run mid-frame: drain to end of frame, no frame_start.
        V_count_value = 16'd100; run = 1'b0;
        step(1);
        check("drain_busy", busy, 1);
        to_line_start();
        V_count_value = 16'd524;
        k = 0; fs_cnt = 0;
        while (busy && k < c_LINE + 10) begin
            if (frame_start) fs_cnt++;
            step(1); k++;
        end
        check("drain_clks_to_idle", k, c_LINE);
        check("drain_no_fs", fs_cnt, 0);
        check("idle_H", H_count_value, 0);
        step(5);
        check("idle_stays", busy, 0);

        // Restart, drop and re-request within drain.
        V_count_value = 16'd10; run = 1'b1;
        step(1);
        check("restart_fs", frame_start, 1);
        step($urandom_range(100, 2000));
        run = 1'b0;
        step($urandom_range(10, 500));
        run = 1'b1;
        step(1);
        check("rerun_busy", busy, 1);
        to_line_start();
        V_count_value = 16'd524;
        fs_cnt = 0; both = 0;
        for (int i = 0; i < c_LINE; i++) begin
            if (frame_start) fs_cnt++;
            if (frame_start && enable_V_counter) both++;
            step(1);
        end
        check("rerun_fs_count", fs_cnt, 1);
        check("rerun_fs_with_envc", both, 1);
        V_count_value = 16'd20;

        // Asynchronous reset in the middle of hsync.
        k = 0;
        while (m_h() != 700 && k < c_LINE + 10) begin step(1); k++; end
        check("reached_H700", H_count_value, 700);
        #2 reset = 1'b0;
        #1;
        check("async_hsync", hsync, 1);
        check("async_H", H_count_value, 0);
        check("async_busy", busy, 0);
        step(2);
        reset = 1'b1;
        step(1);
        check("post_reset_fs", frame_start, 1);
        check("post_reset_H", H_count_value, 0);

        // Randomised run/vertical stimulus, checked every cycle by the model.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: V_count_value = 16'($urandom_range(0, 529));
                3:       V_count_value = 16'(489 + $urandom_range(0, 3));
                4:       V_count_value = 16'(479 + $urandom_range(0, 1));
                5, 6:    V_count_value = 16'd524;
                7:       V_count_value = 16'd523;
                default: V_count_value = 16'd100;
            endcase
            if ($urandom_range(0, 3) == 0) run = ~run;
            step($urandom_range(1, 800));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_controller.md
VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch pixels; H_TOTAL = sum of H params (800).
REQ-005 SHALL have parameter V_VISIBLE, default 480; V_SYNC_START default 490; V_SYNC_LEN default 2; V_TOTAL default 525.
REQ-006 SHALL have parameter PIXEL_DIV, default 4, system clocks per pixel (legal range 1..16).
REQ-007 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port run, input, 1, level request to generate video timing.
REQ-010 SHALL have port V_count_value, input, 16, current line from the external vertical counter.
REQ-011 SHALL have port enable_V_counter, output, 1, one-clk advance strobe to the external vertical counter.
REQ-012 SHALL have port H_count_value, output, 16, current pixel within line.
REQ-013 SHALL have ports pixel_tick, hsync, vsync, video_on, frame_start, busy, each output, 1.

Function
REQ-014 SHALL implement control FSM states IDLE, RUN, DRAIN; busy = (state != IDLE).
REQ-015 SHALL in IDLE hold divider and H_count_value at 0, pixel_tick=0, enable_V_counter=0, hsync=1, vsync=1, video_on=0.
REQ-016 SHALL move IDLE->RUN on the clk after run=1 is sampled; frame_start pulses one clk on that transition edge.
REQ-017 SHALL in RUN/DRAIN count divider 0..PIXEL_DIV-1 and assert pixel_tick for one clk when divider = PIXEL_DIV-1 (every clk if PIXEL_DIV=1).
REQ-018 SHALL advance H_count_value by 1 only on pixel_tick; at H_TOTAL-1 with pixel_tick, wrap to 0.
REQ-019 SHALL assert enable_V_counter for exactly the clk in which pixel_tick=1 and H_count_value=H_TOTAL-1; never otherwise.
REQ-020 SHALL keep horizontal phase FSM ACTIVE [0,H_VISIBLE-1], FRONT, SYNC [H_VISIBLE+H_FP, +H_SYNC-1], BACK, changing phase on the same edge H_count_value crosses each boundary.
REQ-021 SHALL drive hsync=0 only in phase SYNC (656..751 by default), 1 otherwise.
REQ-022 SHALL drive vsync=0 while V_count_value in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN-1] and busy=1.
REQ-023 SHALL drive video_on=1 only when busy, phase ACTIVE and V_count_value < V_VISIBLE.
REQ-024 SHALL pulse frame_start one clk coincident with enable_V_counter when V_count_value = V_TOTAL-1 (end of frame), in RUN only.
REQ-025 SHALL move RUN->DRAIN when run=0 is sampled; DRAIN continues timing unchanged.
REQ-026 SHALL move DRAIN->IDLE on the end-of-frame strobe (H=H_TOTAL-1, V=V_TOTAL-1, pixel_tick); no frame_start issued.
REQ-027 SHALL move DRAIN->RUN if run=1 is sampled before end of frame, with no timing discontinuity.
REQ-028 SHALL treat V_count_value >= V_TOTAL as out-of-frame: vsync=1, video_on=0, no frame_start.

Reset
REQ-029 SHALL on reset=0 immediately (asynchronously) force state IDLE, divider 0, H_count_value 0, phase ACTIVE, and all outputs to IDLE values of REQ-015, busy=0, frame_start=0.
REQ-030 SHALL on reset release mid-frame resume only via IDLE->RUN; no partial-frame strobes after release.

Verification
REQ-031 SHALL bench: reset low, run=1 -> all outputs at reset values; release -> frame_start at first edge, pixel_tick every 4th clk.
REQ-032 SHALL bench: run=1 one line -> hsync low for H 656..751 (384 clks), one enable_V_counter per 3200 clks at H=799.
REQ-033 SHALL bench: V_count_value driven 489..492 -> vsync low only at 490,491; video_on=0 for V>=480.
REQ-034 SHALL bench: run dropped at V=100 -> busy stays 1 until H=799,V=524 strobe, then IDLE, no frame_start.
REQ-035 SHALL bench: run dropped then reasserted within DRAIN -> state RUN, H count continuous, frame_start at next frame end.
REQ-036 SHALL bench: reset asserted with H=700 mid-sync -> hsync=1, H_count_value=0, busy=0 same cycle before next clk edge.
